gate_scanner: RTL and testbench

GATE_SCANNER -- requirements
Module: gate_scanner

---
 rtl/gate_scanner_pkg.sv | 27 ++
 rtl/gate_bank.sv | 25 ++
 rtl/gate_cell.sv | 26 ++
 rtl/gate_scanner.sv | 126 ++++++++++++
 tb/tb_gate_scanner.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gate_scanner_pkg.sv
// Shared types and golden truth tables for the gate scanner.
package gate_scanner_pkg;

    typedef enum logic [2:0] {
        OpAnd  = 3'd0,
        OpOr   = 3'd1,
        OpNot  = 3'd2,
        OpNand = 3'd3,
        OpNor  = 3'd4,
        OpXor  = 3'd5,
        OpXnor = 3'd6,
        OpBuf  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Nibble k is the expected table of op k; bit r holds the output for row r = {a, b}.
    localparam logic [7:0][3:0] GOLDEN = {
        4'hC, 4'h9, 4'h6, 4'h1, 4'h7, 4'h3, 4'hE, 4'h8
    };

endpackage

// File: rtl/gate_bank.sv
// The eight gates under test plus an 8:1 output mux selected by op_sel.
module gate_bank
    import gate_scanner_pkg::*;
(
    input  logic [2:0] i_op_sel,
    input  logic       i_a,
    input  logic       i_b,
    output logic       o_y
);

    logic [7:0] w_y;

    for (genvar k = 0; k < 8; k++) begin : g_cell
        gate_cell #(
            .OP(op_e'(3'(k)))
        ) u_cell (
            .i_a(i_a),
            .i_b(i_b),
            .o_y(w_y[k])
        );
    end

    assign o_y = w_y[i_op_sel];

endmodule

// File: rtl/gate_cell.sv
// One two-input logic gate whose function is fixed by parameter OP.
module gate_cell
    import gate_scanner_pkg::*;
#(
    parameter op_e OP = OpAnd
) (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);

    always_comb begin
        unique case (OP)
            OpAnd:   o_y = i_a & i_b;
            OpOr:    o_y = i_a | i_b;
            OpNot:   o_y = ~i_a;
            OpNand:  o_y = ~(i_a & i_b);
            OpNor:   o_y = ~(i_a | i_b);
            OpXor:   o_y = i_a ^ i_b;
            OpXnor:  o_y = ~(i_a ^ i_b);
            OpBuf:   o_y = i_a;
            default: o_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_scanner.sv
// Walks all eight gates through four input rows and captures their truth tables.
// Define GATE_SCANNER_CHECK_EN to compare captured tables against GOLDEN into mismatch.
module gate_scanner
    import gate_scanner_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [2:0]  op_sel,
    output logic        stim_a,
    output logic        stim_b,
    input  logic        gate_in,
    output logic [31:0] table_out,
    output logic [7:0]  mismatch
);

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

    state_e      r_state, w_state_next;
    logic [2:0]  r_op, w_op_next;
    logic [1:0]  r_row, w_row_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic [31:0] r_table, w_table_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_op    <= 3'd0;
            r_row   <= 2'd0;
            r_cnt   <= 4'd0;
            r_table <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_op    <= w_op_next;
            r_row   <= w_row_next;
            r_cnt   <= w_cnt_next;
            r_table <= w_table_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_row_next   = r_row;
        w_cnt_next   = r_cnt;
        w_table_next = r_table;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StSettle;
                    w_op_next    = 3'd0;
                    w_row_next   = 2'd0;
                    w_cnt_next   = 4'd0;
                    w_table_next = 32'd0;
                end
            end
            StSettle: begin
                if (r_cnt == SettleLast) begin
                    w_cnt_next   = 4'd0;
                    w_state_next = StSample;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            StSample: begin
                w_table_next[{r_op, r_row}] = gate_in;
                // Last vector stays on the bus through DONE; counters clear on the way to IDLE.
                if (r_op == 3'd7 && r_row == 2'd3) begin
                    w_state_next = StDone;
                end else begin
                    w_state_next = StSettle;
                    w_row_next   = r_row + 2'd1;
                    if (r_row == 2'd3) begin
                        w_op_next = r_op + 3'd1;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_op_next    = 3'd0;
                w_row_next   = 2'd0;
            end
            default: w_state_next = StIdle;
        endcase
    end

`ifdef GATE_SCANNER_CHECK_EN
    logic [7:0] r_mismatch, w_mismatch_next;

    // Evaluated on the final capture edge so the flags are valid while done is high.
    always_comb begin
        w_mismatch_next = r_mismatch;
        if (r_state == StIdle && start) begin
            w_mismatch_next = 8'd0;
        end else if (r_state == StSample && r_op == 3'd7 && r_row == 2'd3) begin
            for (int k = 0; k < 8; k++) begin
                w_mismatch_next[k] = (w_table_next[k*4 +: 4] != GOLDEN[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch <= 8'd0;
        end else begin
            r_mismatch <= w_mismatch_next;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 8'd0;
`endif

    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StDone);
    assign op_sel    = r_op;
    assign stim_a    = r_row[1];
    assign stim_b    = r_row[0];
    assign table_out = r_table;

endmodule

// File: tb/tb_gate_scanner.sv
// Directed bench for gate_scanner with a scoreboard of expected scan results.
module tb_gate_scanner;
    import gate_scanner_pkg::*;

`ifdef GATE_SCANNER_CHECK_EN
    localparam logic [7:0] XorMm = 8'h20;
`else
    localparam logic [7:0] XorMm = 8'h00;
`endif

    typedef struct packed {
        logic [31:0] tbl;
        logic [7:0]  mm;
        logic [31:0] lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic corrupt = 1'b0;
    int unsigned cyc = 0;
    int unsigned n_assert = 0;
    int unsigned n_fail = 0;
    int unsigned last_done = 0;
    int unsigned last_t0 = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        busy, done, stim_a, stim_b, gate_in, bank_y;
    logic [2:0]  op_sel;
    logic [31:0] table_out;
    logic [7:0]  mismatch;
    logic        busy4, done4, stim_a4, stim_b4, gate_in4;
    logic [2:0]  op_sel4;
    logic [31:0] table_out4;
    logic [7:0]  mismatch4;

    assign gate_in = bank_y ^ (corrupt && op_sel == 3'd5);

    gate_bank u_bank (.i_op_sel(op_sel), .i_a(stim_a), .i_b(stim_b), .o_y(bank_y));

    gate_scanner #(.SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .op_sel(op_sel), .stim_a(stim_a), .stim_b(stim_b), .gate_in(gate_in),
        .table_out(table_out), .mismatch(mismatch)
    );

    gate_bank u_bank4 (.i_op_sel(op_sel4), .i_a(stim_a4), .i_b(stim_b4), .o_y(gate_in4));

    gate_scanner #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .op_sel(op_sel4), .stim_a(stim_a4), .stim_b(stim_b4), .gate_in(gate_in4),
        .table_out(table_out4), .mismatch(mismatch4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_drive"}, 32'({op_sel, stim_a, stim_b}), 32'd0);
        chk({tag, "_table"}, table_out, 32'd0);
        chk({tag, "_mm"}, 32'(mismatch), 32'd0);
    endtask

    // Waits for done on the SETTLE_CYCLES=1 instance and scores it against the queue head.
    task automatic wait_scan(input int unsigned bound, input bit hold);
        bit prev, seen;
        int unsigned t0;
        exp_t e;
        prev = busy;
        seen = 1'b0;
        t0 = 0;
        for (int n = 0; n < int'(bound); n++) begin
            @(negedge clk);
            if (busy && !prev) begin
                t0 = cyc;
                if (!hold) start = 1'b0;
            end
            prev = busy;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (seen) begin
                chk("latency", cyc - t0, e.lat);
                chk("table", table_out, e.tbl);
                chk("mismatch", 32'(mismatch), 32'(e.mm));
            end
        end
        last_done = cyc;
        last_t0 = t0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_drive", 32'({op_sel, stim_a, stim_b}), 32'd0);
    endtask

    initial begin
        int unsigned d1, run, t0;
        bit found, any_done, prev, seen;
        logic [4:0] pair, pair_prev;
        exp_t e;

        #1;
        check_reset_state("rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("post_rst");

        // Clean scan.
        sb.push_back('{32'hC96173E8, 8'h00, 32'd64});
        start = 1'b1;
        wait_scan(200, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold_table", table_out, 32'hC96173E8);

        // XOR inverted downstream.
        corrupt = 1'b1;
        sb.push_back('{32'hC99173E8, XorMm, 32'd64});
        start = 1'b1;
        wait_scan(200, 1'b0);
        corrupt = 1'b0;

        // Start held high: one done, then a back-to-back scan.
        sb.push_back('{32'hC96173E8, 8'h00, 32'd64});
        sb.push_back('{32'hC96173E8, 8'h00, 32'd64});
        start = 1'b1;
        wait_scan(200, 1'b1);
        d1 = last_done;
        wait_scan(200, 1'b0);
        chk("b2b_gap", last_t0 - d1, 32'd2);

        // Reset while op=3, row=2 is on the bus.
        start = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (busy) start = 1'b0;
            if (busy && op_sel == 3'd3 && stim_a && !stim_b) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_op3_row2", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_state("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) any_done = 1'b1;
        end
        chk("no_restart", 32'(any_done), 32'd0);
        sb.push_back('{32'hC96173E8, 8'h00, 32'd64});
        start = 1'b1;
        wait_scan(200, 1'b0);

        // SETTLE_CYCLES=4 instance: 5-cycle holds in row order.
        sb.push_back('{32'hC96173E8, 8'h00, 32'd160});
        start4 = 1'b1;
        prev = 1'b0;
        seen = 1'b0;
        t0 = 0;
        run = 0;
        pair_prev = 5'd0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy4 && !prev) begin
                t0 = cyc;
                start4 = 1'b0;
            end
            prev = busy4;
            if (done4) begin
                seen = 1'b1;
                break;
            end
            if (busy4) begin
                pair = {op_sel4, stim_a4, stim_b4};
                if (run == 0) begin
                    chk("s4_first_vec", 32'(pair), 32'd0);
                end else if (pair != pair_prev) begin
                    chk("s4_hold", run, 32'd5);
                    chk("s4_order", 32'(pair), 32'(pair_prev + 5'd1));
                    run = 0;
                end
                pair_prev = pair;
                run++;
            end
        end
        chk("s4_done_seen", 32'(seen), 32'd1);
        chk("s4_last_hold", run, 32'd5);
        chk("s4_last_vec", 32'(pair_prev), 32'd31);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("s4_latency", cyc - t0, e.lat);
            chk("s4_table", table_out4, e.tbl);
            chk("s4_mm", 32'(mismatch4), 32'(e.mm));
        end
        @(negedge clk);
        chk("s4_done_pulse", 32'(done4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
